// File: rtl/key_repeat.sv
// Key press / auto-repeat event generator driven by the debounced key level and press edge.
// Optional KEY_REPEAT_ACCEL_EN switches to the fast repeat period after ACCEL_REPEATS repeats.
module key_repeat #(
  parameter int unsigned CNT_BITS      = 4,
  parameter int unsigned DELAY_TICKS   = 10,
  parameter int unsigned RATE_TICKS    = 3,
  parameter int unsigned ACCEL_REPEATS = 4,
  parameter int unsigned FAST_TICKS    = 1
) (
  input  logic CLK,
  input  logic CLR,
  input  logic CE,
  input  logic KEY_EN,
  input  logic KEY_UP,
  output logic KEY_PULSE,
  output logic REPEATING
);

  localparam logic [CNT_BITS-1:0] ONE       = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] DELAY_VAL = CNT_BITS'(DELAY_TICKS);
  localparam logic [CNT_BITS-1:0] RATE_VAL  = CNT_BITS'(RATE_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] reload;
  logic                pulse_d;

`ifdef KEY_REPEAT_ACCEL_EN
  localparam logic [CNT_BITS-1:0] ACCEL_VAL = CNT_BITS'(ACCEL_REPEATS);
  localparam logic [CNT_BITS-1:0] FAST_VAL  = CNT_BITS'(FAST_TICKS);

  logic [CNT_BITS-1:0] rep_q, rep_d, rep_inc;

  // Repeat count: starts at 1 on the first repeat, saturates, clears on leaving REPEAT.
  always_comb begin
    rep_inc = (rep_q == '1) ? rep_q : rep_q + ONE;
    reload  = (rep_inc >= ACCEL_VAL) ? FAST_VAL : RATE_VAL;
    rep_d   = rep_q;
    if (state_q == DELAY && state_d == REPEAT) begin
      rep_d = ONE;
    end else if (state_q == REPEAT && state_d == IDLE) begin
      rep_d = '0;
    end else if (state_q == REPEAT && pulse_d) begin
      rep_d = rep_inc;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_accel_params;
  assign unused_accel_params = ^{CNT_BITS'(ACCEL_REPEATS), CNT_BITS'(FAST_TICKS)};
  assign reload = RATE_VAL;
`endif

  // State, tick counter and registered outputs.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      KEY_PULSE <= 1'b0;
      REPEATING <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      KEY_PULSE <= pulse_d;
      REPEATING <= (state_d == REPEAT);
    end
  end

  // Next state; release takes priority over expiry on the same CE tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (KEY_UP) begin
          pulse_d = 1'b1;
          cnt_d   = DELAY_VAL;
          state_d = DELAY;
        end
      end
      DELAY: begin
        if (CE) begin
          if (!KEY_EN) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ONE) begin
            pulse_d = 1'b1;
            cnt_d   = RATE_VAL;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      REPEAT: begin
        if (CE) begin
          if (!KEY_EN) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ONE) begin
            pulse_d = 1'b1;
            cnt_d   = reload;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_repeat.sv
// Scoreboard bench for key_repeat: stimulus pushes expected pulse tick ids, a monitor pops them.
// Honours KEY_REPEAT_ACCEL_EN for the expected repeat spacing.
module tb_key_repeat;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic CE = 1'b0;
  logic KEY_EN = 1'b0;
  logic KEY_UP = 1'b0;
  logic KEY_PULSE;
  logic REPEATING;

  int tests = 0;
  int fails = 0;
  int tick_id = 0;
  int base = 0;
  int exp_q[$];

  key_repeat dut (
    .CLK(CLK),
    .CLR(CLR),
    .CE(CE),
    .KEY_EN(KEY_EN),
    .KEY_UP(KEY_UP),
    .KEY_PULSE(KEY_PULSE),
    .REPEATING(REPEATING)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
    end
  endtask

  // One CE tick with the given inputs, then three idle clocks.
  task automatic tick(input logic en, input logic up);
    @(negedge CLK);
    CE = 1'b1;
    KEY_EN = en;
    KEY_UP = up;
    tick_id++;
    @(negedge CLK);
    CE = 1'b0;
    KEY_UP = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic expect_pulses(input int offs[]);
    foreach (offs[i]) exp_q.push_back(base + offs[i]);
  endtask

  // Monitor: every pulse must follow a CE edge and match the next expected tick id.
  initial begin
    logic ce_s;
    int got;
    int want;
    forever begin
      @(posedge CLK);
      ce_s = CE;
      #1;
      if (KEY_PULSE === 1'b1) begin
        got = ce_s ? tick_id : -1;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse got tick=%0d want none at %0t", got, $time);
        end else begin
          want = exp_q.pop_front();
          if (got != want) begin
            fails++;
            $display("FAIL pulse_tick got tick=%0d want tick=%0d at %0t", got, want, $time);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_pulse", KEY_PULSE, 1'b0);
    check("reset_repeating", REPEATING, 1'b0);
    CLR = 1'b0;
    repeat (2) @(negedge CLK);

    // Short press: one pulse, no repeat.
    base = tick_id + 1;
    expect_pulses('{0});
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    check("short_repeating", REPEATING, 1'b0);
    repeat (3) tick(1'b0, 1'b0);

    // Long hold through 22 ticks, then release.
    base = tick_id + 1;
`ifdef KEY_REPEAT_ACCEL_EN
    expect_pulses('{0, 10, 13, 16, 19, 20, 21, 22});
`else
    expect_pulses('{0, 10, 13, 16, 19, 22});
`endif
    tick(1'b1, 1'b1);
    for (int i = 1; i <= 22; i++) begin
      tick(1'b1, 1'b0);
      if (i == 9) check("hold_rep_before", REPEATING, 1'b0);
      if (i == 10) check("hold_rep_first", REPEATING, 1'b1);
    end
    check("hold_rep_held", REPEATING, 1'b1);
    tick(1'b0, 1'b0);
    check("hold_rep_release", REPEATING, 1'b0);
    tick(1'b0, 1'b0);

    // Release on the expiry tick: no tick-10 pulse; level alone does not restart.
    base = tick_id + 1;
    expect_pulses('{0});
    tick(1'b1, 1'b1);
    repeat (9) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("expiry_release_rep", REPEATING, 1'b0);
    repeat (5) tick(1'b1, 1'b0);
    check("level_no_start_rep", REPEATING, 1'b0);
    tick(1'b0, 1'b0);

    // CE stalled for 100 clocks in DELAY; countdown resumes afterwards.
    base = tick_id + 1;
    expect_pulses('{0, 10});
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    repeat (100) @(negedge CLK);
    check("stall_rep", REPEATING, 1'b0);
    repeat (5) tick(1'b1, 1'b0);
    check("stall_rep_tick9", REPEATING, 1'b0);
    tick(1'b1, 1'b0);
    check("stall_rep_tick10", REPEATING, 1'b1);
    tick(1'b0, 1'b0);
    check("stall_rep_release", REPEATING, 1'b0);

    // Asynchronous clear while a repeat pulse is high.
    base = tick_id + 1;
    expect_pulses('{0, 10, 13});
    tick(1'b1, 1'b1);
    repeat (12) tick(1'b1, 1'b0);
    @(negedge CLK);
    CE = 1'b1;
    KEY_EN = 1'b1;
    tick_id++;
    @(posedge CLK);
    #3;
    check("pre_clr_pulse", KEY_PULSE, 1'b1);
    check("pre_clr_rep", REPEATING, 1'b1);
    CLR = 1'b1;
    #1;
    check("async_clr_pulse", KEY_PULSE, 1'b0);
    check("async_clr_rep", REPEATING, 1'b0);
    @(negedge CLK);
    CE = 1'b0;
    repeat (2) @(negedge CLK);
    CLR = 1'b0;
    repeat (30) tick(1'b1, 1'b0);
    check("post_clr_rep", REPEATING, 1'b0);
    tick(1'b0, 1'b0);

    repeat (4) @(negedge CLK);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses got %0d outstanding want 0 (next tick=%0d)", exp_q.size(), exp_q[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
